// File: rtl/mem_arbiter.sv
// Byte-serial memory bus arbiter between instruction fetch (IF) and load/store (LS).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise LS has fixed priority.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_data,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [2:0]        ls_size,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_ack,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   input  logic [7:0]        mem_din
);

   localparam int NBYTES = DATA_W / 8;
   localparam int IDX_W  = $clog2(NBYTES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_DRAIN,
      S_ACK
   } state_t;

   // FSM and bus-side registers
   state_t              r_state;
   logic [IDX_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_mem_a;
   logic [7:0]          r_mem_dout;
   logic                r_mem_wr;
   logic                r_if_ack;
   logic                r_ls_ack;

   // Transfer context latched at grant
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic [IDX_W-1:0]    r_last_idx;
   logic                r_sel_ls;
   logic [DATA_W-1:0]   r_buf;
   logic [DATA_W-1:0]   r_if_data;
   logic [DATA_W-1:0]   r_ls_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                r_last_ls;
`endif

   // Combinational next-state and control
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    w_cnt_nxt;
   logic [IDX_W-1:0]    w_cnt_inc;
   logic [IDX_W-1:0]    w_cnt_dec;
   logic [ADDR_W-1:0]   w_mem_a_nxt;
   logic [7:0]          w_mem_dout_nxt;
   logic                w_mem_wr_nxt;
   logic                w_if_ack_nxt;
   logic                w_ls_ack_nxt;
   logic                w_grant;
   logic                w_grant_ls;
   logic                w_grant_if;
   logic                w_ls_size_ok;
   logic [IDX_W-1:0]    w_ls_idx;
   logic                w_capture;
   logic [IDX_W-1:0]    w_cap_idx;
   logic                w_load_if;
   logic                w_load_ls;
   logic [DATA_W-1:0]   w_word;

   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_cnt_dec = r_cnt - 1'b1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // On contention the port that was not granted last wins.
   assign w_grant_ls = ls_req && (!if_req || !r_last_ls);
`else
   assign w_grant_ls = ls_req;
`endif
   assign w_grant_if = if_req && !w_grant_ls;

   always_comb begin
      w_ls_size_ok = 1'b1;
      w_ls_idx     = '0;
      case (ls_size)
         3'd1:    w_ls_idx = IDX_W'(0);
         3'd2:    w_ls_idx = IDX_W'(1);
         3'd4:    w_ls_idx = IDX_W'(3);
         default: w_ls_size_ok = 1'b0;
      endcase
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path infers a latch.
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_mem_a_nxt    = '0;
      w_mem_dout_nxt = '0;
      w_mem_wr_nxt   = 1'b0;
      w_if_ack_nxt   = 1'b0;
      w_ls_ack_nxt   = 1'b0;
      w_grant        = 1'b0;
      w_capture      = 1'b0;
      w_cap_idx      = w_cnt_dec;
      w_load_if      = 1'b0;
      w_load_ls      = 1'b0;
      w_word         = r_buf;

      unique case (r_state)
         S_IDLE: begin
            if (w_grant_ls && !w_ls_size_ok) begin
               // Illegal size: no bus cycle, just acknowledge with zero data.
               w_grant      = 1'b1;
               w_state_nxt  = S_ACK;
               w_ls_ack_nxt = 1'b1;
               w_load_ls    = 1'b1;
               w_word       = '0;
            end else if (w_grant_ls || w_grant_if) begin
               w_grant        = 1'b1;
               w_state_nxt    = S_XFER;
               w_cnt_nxt      = '0;
               w_mem_a_nxt    = w_grant_ls ? ls_addr : if_addr;
               w_mem_wr_nxt   = w_grant_ls && ls_we;
               w_mem_dout_nxt = (w_grant_ls && ls_we) ? ls_wdata[7:0] : 8'h00;
            end
         end

         S_XFER: begin
            // The RAM answers one cycle late, so byte k-1 arrives while byte k is addressed.
            w_capture = (r_cnt != '0) && !r_we;
            if (r_cnt == r_last_idx) begin
               if (r_we) begin
                  w_state_nxt  = S_ACK;
                  w_if_ack_nxt = !r_sel_ls;
                  w_ls_ack_nxt = r_sel_ls;
               end else begin
                  w_state_nxt = S_DRAIN;
               end
            end else begin
               w_cnt_nxt      = w_cnt_inc;
               w_mem_a_nxt    = r_addr + ADDR_W'(w_cnt_inc);
               w_mem_wr_nxt   = r_we;
               w_mem_dout_nxt = r_we ? r_wdata[8*w_cnt_inc +: 8] : 8'h00;
            end
         end

         S_DRAIN: begin
            w_capture                    = 1'b1;
            w_cap_idx                    = r_last_idx;
            w_word[8*r_last_idx +: 8]    = mem_din;
            w_load_if                    = !r_sel_ls;
            w_load_ls                    = r_sel_ls;
            w_if_ack_nxt                 = !r_sel_ls;
            w_ls_ack_nxt                 = r_sel_ls;
            w_state_nxt                  = S_ACK;
         end

         S_ACK: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state and registered bus outputs; rdy low freezes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_mem_a    <= '0;
         r_mem_dout <= '0;
         r_mem_wr   <= 1'b0;
         r_if_ack   <= 1'b0;
         r_ls_ack   <= 1'b0;
      end else if (rdy) begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_mem_a    <= w_mem_a_nxt;
         r_mem_dout <= w_mem_dout_nxt;
         r_mem_wr   <= w_mem_wr_nxt;
         r_if_ack   <= w_if_ack_nxt;
         r_ls_ack   <= w_ls_ack_nxt;
      end
   end

   // Transfer context, read assembly and returned data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_last_idx <= '0;
         r_sel_ls   <= 1'b0;
         r_buf      <= '0;
         r_if_data  <= '0;
         r_ls_rdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         r_last_ls  <= 1'b0;
`endif
      end else if (rdy) begin
         if (w_grant) begin
            r_addr     <= w_grant_ls ? ls_addr : if_addr;
            r_we       <= w_grant_ls && ls_we;
            r_wdata    <= w_grant_ls ? ls_wdata : '0;
            r_last_idx <= w_grant_ls ? w_ls_idx : IDX_W'(NBYTES - 1);
            r_sel_ls   <= w_grant_ls;
            r_buf      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_ls  <= w_grant_ls;
`endif
         end else if (w_capture) begin
            r_buf[8*w_cap_idx +: 8] <= mem_din;
         end
         if (w_load_if) begin
            r_if_data <= w_word;
         end
         if (w_load_ls) begin
            r_ls_rdata <= w_word;
         end
      end
   end

   assign if_ack   = r_if_ack;
   assign ls_ack   = r_ls_ack;
   assign if_data  = r_if_data;
   assign ls_rdata = r_ls_rdata;
   assign mem_a    = r_mem_a;
   assign mem_dout = r_mem_dout;
   assign mem_wr   = r_mem_wr && rdy;

endmodule
